// File: rtl/layer_hit_injector.sv
// Test-pattern transmitter: replays six loaded 64-bit layer patterns as timed pulses
// with programmable delay, width, inter-layer skew and burst repetition.
//
// state | meaning
// IDLE  | waiting for start; pattern registers writable
// DELAY | counting down the start delay
// PULSE | phase counter t sweeps every layer window of one burst
// GAP   | idle cycles between bursts
module layer_hit_injector #(
    parameter int LYW = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_wr,
    input  logic [2:0]     cfg_layer,
    input  logic [LYW-1:0] cfg_data,
    input  logic [7:0]     delay,
    input  logic [3:0]     width,
    input  logic [2:0]     skew,
    input  logic [3:0]     repeat_cnt,
    input  logic [7:0]     gap,
    input  logic           inj_start,
    input  logic           trig_stop,
    output logic [LYW-1:0] ly0,
    output logic [LYW-1:0] ly1,
    output logic [LYW-1:0] ly2,
    output logic [LYW-1:0] ly3,
    output logic [LYW-1:0] ly4,
    output logic [LYW-1:0] ly5,
    output logic           busy,
    output logic           done
);

    localparam int NLY = 6;

    typedef enum logic [1:0] {IDLE, DELAY, PULSE, GAP} state_t;

    state_t         state, state_nx;
    logic [7:0]     cnt, cnt_nx;
    logic [5:0]     t, t_nx;
    logic [3:0]     burst, burst_nx;
    logic           done_nx;
    logic           start_acc;

    logic [3:0]     sh_w;
    logic [3:0]     sh_rep;
    logic [2:0]     sh_skew;
    logic [7:0]     sh_gap;
    logic [6:0]     span_last;

    logic [LYW-1:0] pat   [NLY];
    logic [LYW-1:0] ly_q  [NLY];
    logic [LYW-1:0] ly_nx [NLY];

    // Last phase of a burst: layer 5 window closes at 5*skew + w - 1.
    assign span_last = 7'(5 * int'(sh_skew)) + 7'(sh_w) - 7'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            t       <= '0;
            burst   <= '0;
            done    <= 1'b0;
            sh_w    <= '0;
            sh_rep  <= '0;
            sh_skew <= '0;
            sh_gap  <= '0;
            for (int k = 0; k < NLY; k++) begin
                pat[k]  <= '0;
                ly_q[k] <= '0;
            end
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            t     <= t_nx;
            burst <= burst_nx;
            done  <= done_nx;
            for (int k = 0; k < NLY; k++) begin
                ly_q[k] <= ly_nx[k];
                if (cfg_wr && state == IDLE && cfg_layer == 3'(k))
                    pat[k] <= cfg_data;
            end
            if (start_acc) begin
                sh_w    <= (width == 4'd0) ? 4'd1 : width;
                sh_rep  <= repeat_cnt;
                sh_skew <= skew;
                sh_gap  <= gap;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        t_nx      = t;
        burst_nx  = burst;
        done_nx   = 1'b0;
        start_acc = 1'b0;

        case (state)
            IDLE: begin
                if (inj_start && !trig_stop) begin
                    start_acc = 1'b1;
                    state_nx  = DELAY;
                    cnt_nx    = delay;
                    t_nx      = '0;
                    burst_nx  = '0;
                end
            end
            DELAY: begin
                if (cnt == 8'd0) begin
                    state_nx = PULSE;
                    t_nx     = '0;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            PULSE: begin
                if ({1'b0, t} == span_last) begin
                    t_nx = '0;
                    if (burst == sh_rep) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        burst_nx = burst + 4'd1;
                        // gap=0 chains straight into the next burst so pulses can merge
                        if (sh_gap == 8'd0) begin
                            state_nx = PULSE;
                        end else begin
                            state_nx = GAP;
                            cnt_nx   = sh_gap - 8'd1;
                        end
                    end
                end else begin
                    t_nx = t + 6'd1;
                end
            end
            GAP: begin
                if (cnt == 8'd0) begin
                    state_nx = PULSE;
                    t_nx     = '0;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (state != IDLE && trig_stop) begin
            state_nx = IDLE;
            done_nx  = 1'b0;
        end

        // Outputs are registered, so the window is evaluated on the next phase value.
        for (int k = 0; k < NLY; k++) begin
            ly_nx[k] = '0;
            if (state_nx == PULSE
                && {1'b0, t_nx} >= 7'(k * int'(sh_skew))
                && {1'b0, t_nx} <  7'(k * int'(sh_skew)) + 7'(sh_w))
                ly_nx[k] = pat[k];
        end
    end

    assign busy = (state != IDLE);
    assign ly0  = ly_q[0];
    assign ly1  = ly_q[1];
    assign ly2  = ly_q[2];
    assign ly3  = ly_q[3];
    assign ly4  = ly_q[4];
    assign ly5  = ly_q[5];

endmodule

// File: doc/layer_hit_injector.md
Name: layer_hit_injector

Overview:
- Test-pattern transmitter that drives synthetic anode hit patterns into the per-layer input of the chamber one-shot stage (6 layers x 64 wiregroups).
- Software loads one 64-bit pattern per layer, then a start strobe replays the patterns as multi-cycle pulses with programmable delay, width, inter-layer skew and burst repetition.
- Shares the trig_stop input with the one-shot stage; the two blocks are halted together.

Parameters:
- LYW, 64, wiregroups per layer; width of cfg_data and ly0..ly5.
- NLY, 6, layer count; fixed, not overridable.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_wr  in  1  pattern-write strobe.
- cfg_layer  in  3  target layer for cfg_wr, 0..5.
- cfg_data  in  LYW  pattern bits for the addressed layer.
- delay  in  8  cycles from start to the first pulse.
- width  in  4  pulse width in cycles; 0 is treated as 1.
- skew  in  3  extra delay per layer index (layer k delayed k*skew).
- repeat  in  4  additional bursts after the first (total repeat+1).
- gap  in  8  idle cycles between bursts.
- inj_start  in  1  one-cycle start strobe.
- trig_stop  in  1  synchronous abort/inhibit.
- ly0..ly5  out  LYW each  registered injected hit patterns.
- busy  out  1  high from the start acceptance edge until return to IDLE.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async, rst_n=0):
  - Pattern registers, all counters and shadow registers clear.
  - FSM goes to IDLE.
  - ly0..ly5=0, busy=0, done=0.
- Pattern load:
  - cfg_wr=1 with cfg_layer<=5 and busy=0: the addressed pattern register takes cfg_data at the edge.
  - cfg_layer 6/7, or a write while busy=1, is ignored.
- Start:
  - inj_start=1 in IDLE with trig_stop=0: delay/width/skew/repeat/gap are captured into shadow registers; busy=1 after that edge (E0).
  - inj_start while busy=1 or trig_stop=1 is ignored.
- FSM states: IDLE, DELAY, PULSE, GAP.
  - IDLE -> DELAY on an accepted start.
  - DELAY counts delay cycles. delay=0 passes straight to PULSE, with no extra cycle.
  - PULSE runs a 6-bit phase counter t = 0 .. 5*skew+w-1, where w = max(width,1). Maximum span is 50.
  - When the burst count equals repeat: PULSE -> IDLE.
  - Otherwise: PULSE -> GAP, which counts gap cycles and then returns to PULSE. gap=0 starts the next burst immediately.
- Output timing (outputs registered):
  - During PULSE, lyk = pattern[k] when k*skew <= t < k*skew+w, else 0.
  - First visible assertion of layer k follows edge E0+1+delay+k*skew.
  - Layer k stays asserted for exactly w cycles.
  - Outputs are 0 in IDLE, DELAY and GAP.
  - With gap=0 and skew=0, consecutive bursts merge into one continuous assertion; no forced zero cycle.
- Completion: on the edge where the final PULSE cycle ends, FSM -> IDLE, busy=0, done=1 for one cycle, all ly=0.
  - inj_start is accepted in the same cycle done is high.
- Abort: trig_stop=1 in any non-IDLE state at an edge means:
  - next cycle: FSM IDLE, all ly=0, busy=0, done stays 0;
  - pattern registers are retained.
- Reset mid-burst: outputs drop to 0 immediately (async); pattern registers are cleared.
- Live parameter inputs may change during a burst without effect; only the shadow copies are used.

Test Plan:
- Reset/load: assert rst_n=0 mid-burst -> all ly=0, busy=0 immediately. Load layer2=0x0000_0000_0000_00FF and layer7 write -> only ly2 reg updated, layer7 write has no effect.
- Basic shot: all layers pattern 0xAAAA..., delay=0, width=1, skew=0, repeat=0, start at E0 -> all ly=0xAAAA... for exactly one cycle after E1, done pulses after E2, busy high E0..E2.
- Skew/width: delay=3, width=2, skew=1 -> ly0 high cycles after E4,E5; ly5 high after E9,E10; done after E11; width=0 yields one-cycle pulses.
- Repeat/gap: delay=0, width=1, skew=0, repeat=2, gap=3 -> three one-cycle pulses spaced 4 cycles apart, single done; gap=0, width=2 -> continuous 6-cycle assertion.
- Abort: trig_stop=1 during PULSE of repeat=5 burst -> next cycle all ly=0, busy=0, no done. inj_start with trig_stop=1 -> ignored, busy stays 0.
- Busy guards: cfg_wr and inj_start during a burst -> pattern unchanged, burst timing unaffected; inj_start in done cycle -> new burst accepted.
